// File: rtl/l2_request_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : l2_request_arbiter                                         |
// | Description : Merges the icache and dcache higher-memory request ports   |
// |               onto the single L2 port. Round-robin between the two       |
// |               clients; a grant stays locked while the granted client     |
// |               holds its request valid, so multi-word fills/writebacks    |
// |               are never interleaved with the other client's traffic.     |
// | Ports       : clk, reset (sync, active-high)                             |
// |               ic_req_*      : icache request in, ic_req_fulfilled out    |
// |               dc_req_*      : dcache request in, dc_req_fulfilled out    |
// |               l2_req_*      : forwarded request out, l2_req_fulfilled in |
// |               l2_rdata/rdata: L2 load data, broadcast to both clients    |
// | Option      : define L2_ARB_PERF_CNT_EN to add the 32-bit saturating     |
// |               counters ic_grant_cycles, dc_grant_cycles and              |
// |               contention_cycles.                                         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

package l2_arb_pkg;
  typedef enum logic {
    LOAD  = 1'b0,
    STORE = 1'b1
  } memory_operation_e;
endpackage

module l2_request_arbiter
  import l2_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              ic_req_valid,
  input  memory_operation_e ic_req_type,
  input  logic [ADDR_W-1:0] ic_req_address,
  output logic              ic_req_fulfilled,

  input  logic              dc_req_valid,
  input  memory_operation_e dc_req_type,
  input  logic [ADDR_W-1:0] dc_req_address,
  input  logic [XLEN-1:0]   dc_req_wdata,
  output logic              dc_req_fulfilled,

  output logic              l2_req_valid,
  output memory_operation_e l2_req_type,
  output logic [ADDR_W-1:0] l2_req_address,
  output logic [XLEN-1:0]   l2_req_wdata,
  input  logic              l2_req_fulfilled,
  input  logic [XLEN-1:0]   l2_rdata,
  output logic [XLEN-1:0]   rdata
`ifdef L2_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       ic_grant_cycles,
  output logic [31:0]       dc_grant_cycles,
  output logic [31:0]       contention_cycles
`endif
);

  localparam logic [1:0] ST_IDLE     = 2'b00;
  localparam logic [1:0] ST_GRANT_IC = 2'b01;
  localparam logic [1:0] ST_GRANT_DC = 2'b10;

  localparam logic C_LAST_IC = 1'b0;
  localparam logic C_LAST_DC = 1'b1;

  logic [1:0] r_state;
  logic [1:0] w_state_next;
  logic       r_last_grant;
  logic       w_last_grant_next;

  // Output mux and next-state logic. The L2 request is a pure combinational
  // pass-through of the owning client, so the cycle in which the owner drops
  // valid issues nothing even though the state is still GRANT_x.
  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    l2_req_valid      = 1'b0;
    l2_req_type       = LOAD;
    l2_req_address    = '0;
    l2_req_wdata      = '0;
    ic_req_fulfilled  = 1'b0;
    dc_req_fulfilled  = 1'b0;
    rdata             = '0;

    case (r_state)
      ST_IDLE: begin
        // Tie goes to whoever was not served last.
        if (ic_req_valid && dc_req_valid) begin
          w_state_next = (r_last_grant == C_LAST_DC) ? ST_GRANT_IC : ST_GRANT_DC;
        end else if (ic_req_valid) begin
          w_state_next = ST_GRANT_IC;
        end else if (dc_req_valid) begin
          w_state_next = ST_GRANT_DC;
        end
      end

      ST_GRANT_IC: begin
        l2_req_valid     = ic_req_valid;
        l2_req_type      = ic_req_type;
        l2_req_address   = ic_req_address;
        ic_req_fulfilled = l2_req_fulfilled;
        rdata            = l2_rdata;
        if (!ic_req_valid) begin
          w_last_grant_next = C_LAST_IC;
          w_state_next      = dc_req_valid ? ST_GRANT_DC : ST_IDLE;
        end
      end

      ST_GRANT_DC: begin
        l2_req_valid     = dc_req_valid;
        l2_req_type      = dc_req_type;
        l2_req_address   = dc_req_address;
        l2_req_wdata     = dc_req_wdata;
        dc_req_fulfilled = l2_req_fulfilled;
        rdata            = l2_rdata;
        if (!dc_req_valid) begin
          w_last_grant_next = C_LAST_DC;
          w_state_next      = ic_req_valid ? ST_GRANT_IC : ST_IDLE;
        end
      end

      default: begin
        // Illegal encoding: poison everything so it is visible in simulation.
        w_state_next      = 2'bxx;
        w_last_grant_next = 1'bx;
        l2_req_valid      = 1'bx;
        l2_req_type       = memory_operation_e'(1'bx);
        l2_req_address    = 'x;
        l2_req_wdata      = 'x;
        ic_req_fulfilled  = 1'bx;
        dc_req_fulfilled  = 1'bx;
        rdata             = 'x;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= C_LAST_DC;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_grant_next;
    end
  end

`ifdef L2_ARB_PERF_CNT_EN
  localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

  logic [31:0] r_ic_grant_cycles;
  logic [31:0] r_dc_grant_cycles;
  logic [31:0] r_contention_cycles;
  logic        w_contention;

  // A client is waiting whenever it is valid and the port belongs to someone
  // else (including the IDLE arbitration cycle).
  assign w_contention = (ic_req_valid && (r_state != ST_GRANT_IC)) ||
                        (dc_req_valid && (r_state != ST_GRANT_DC));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ic_grant_cycles   <= '0;
      r_dc_grant_cycles   <= '0;
      r_contention_cycles <= '0;
    end else begin
      if ((r_state == ST_GRANT_IC) && (r_ic_grant_cycles != C_CNT_MAX)) begin
        r_ic_grant_cycles <= r_ic_grant_cycles + 32'd1;
      end
      if ((r_state == ST_GRANT_DC) && (r_dc_grant_cycles != C_CNT_MAX)) begin
        r_dc_grant_cycles <= r_dc_grant_cycles + 32'd1;
      end
      if (w_contention && (r_contention_cycles != C_CNT_MAX)) begin
        r_contention_cycles <= r_contention_cycles + 32'd1;
      end
    end
  end

  assign ic_grant_cycles   = r_ic_grant_cycles;
  assign dc_grant_cycles   = r_dc_grant_cycles;
  assign contention_cycles = r_contention_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_l2_request_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_l2_request_arbiter                                      |
// | Description : Self-checking bench for l2_request_arbiter. Two client     |
// |               drivers issue random bursts, a random L2 model pulses      |
// |               fulfilled. Each issued word is queued per client; a        |
// |               negedge monitor checks every cycle against an ownership    |
// |               model and pops the scoreboard on each completed word.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_l2_request_arbiter;
  import l2_arb_pkg::*;

  logic              clk;
  logic              reset;
  logic              ic_req_valid;
  memory_operation_e ic_req_type;
  logic [31:0]       ic_req_address;
  logic              ic_req_fulfilled;
  logic              dc_req_valid;
  memory_operation_e dc_req_type;
  logic [31:0]       dc_req_address;
  logic [31:0]       dc_req_wdata;
  logic              dc_req_fulfilled;
  logic              l2_req_valid;
  memory_operation_e l2_req_type;
  logic [31:0]       l2_req_address;
  logic [31:0]       l2_req_wdata;
  logic              l2_req_fulfilled;
  logic [31:0]       l2_rdata;
  logic [31:0]       rdata;
`ifdef L2_ARB_PERF_CNT_EN
  logic [31:0]       ic_grant_cycles;
  logic [31:0]       dc_grant_cycles;
  logic [31:0]       contention_cycles;
`endif

  l2_request_arbiter #(.ADDR_W(32), .XLEN(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .ic_req_valid     (ic_req_valid),
    .ic_req_type      (ic_req_type),
    .ic_req_address   (ic_req_address),
    .ic_req_fulfilled (ic_req_fulfilled),
    .dc_req_valid     (dc_req_valid),
    .dc_req_type      (dc_req_type),
    .dc_req_address   (dc_req_address),
    .dc_req_wdata     (dc_req_wdata),
    .dc_req_fulfilled (dc_req_fulfilled),
    .l2_req_valid     (l2_req_valid),
    .l2_req_type      (l2_req_type),
    .l2_req_address   (l2_req_address),
    .l2_req_wdata     (l2_req_wdata),
    .l2_req_fulfilled (l2_req_fulfilled),
    .l2_rdata         (l2_rdata),
    .rdata            (rdata)
`ifdef L2_ARB_PERF_CNT_EN
    ,
    .ic_grant_cycles  (ic_grant_cycles),
    .dc_grant_cycles  (dc_grant_cycles),
    .contention_cycles(contention_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    memory_operation_e t;
    logic [31:0]       a;
    logic [31:0]       d;
  } word_t;

  word_t exp_ic[$];
  word_t exp_dc[$];

  int checks   = 0;
  int failures = 0;

  // Client driver state, index 0 = icache, 1 = dcache.
  logic              busy[2];
  int                words_left[2];
  int                gap[2];
  logic [31:0]       cur_addr[2];
  logic [31:0]       cur_wdata[2];
  memory_operation_e cur_type[2];
  logic              rnd_en;
  logic              s_fulf[2];

  // Ownership model: 0 none, 1 icache, 2 dcache.
  int   m_owner   = 0;
  logic m_last_dc = 1'b1;
  longint m_icc = 0, m_dcc = 0, m_cont = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: condition not met at %0t", name, $time);
  endtask

  task automatic push_word(input int c);
    word_t w;
    w.t = cur_type[c];
    w.a = cur_addr[c];
    w.d = (c == 0) ? 32'h0 : cur_wdata[c];
    if (c == 0) exp_ic.push_back(w);
    else        exp_dc.push_back(w);
  endtask

  task automatic start_burst(input int c, input int n, input logic [31:0] a,
                             input memory_operation_e t, input logic [31:0] d);
    busy[c]       = 1'b1;
    words_left[c] = n;
    cur_addr[c]   = a;
    cur_type[c]   = t;
    cur_wdata[c]  = d;
    push_word(c);
  endtask

  task automatic drive_ports();
    ic_req_valid   = busy[0];
    ic_req_type    = cur_type[0];
    ic_req_address = cur_addr[0];
    dc_req_valid   = busy[1];
    dc_req_type    = cur_type[1];
    dc_req_address = cur_addr[1];
    dc_req_wdata   = cur_wdata[1];
  endtask

  // One clock of stimulus: clients react to last cycle's fulfilled.
  task automatic step();
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      if (busy[c] && s_fulf[c]) begin
        words_left[c]--;
        if (words_left[c] == 0) begin
          busy[c] = 1'b0;
          gap[c]  = $urandom_range(0, 3);
        end else begin
          cur_addr[c]  = cur_addr[c] + 32'd4;
          cur_wdata[c] = (c == 1) ? $urandom : 32'h0;
          push_word(c);
        end
      end else if (!busy[c] && rnd_en) begin
        if (gap[c] != 0) gap[c]--;
        else if ($urandom_range(0, 2) == 0)
          start_burst(c, $urandom_range(1, 4), $urandom & 32'hFFFF_FFFC,
                      (c == 1 && $urandom_range(0, 1) == 1) ? STORE : LOAD, $urandom);
      end
    end
    l2_req_fulfilled = ($urandom_range(0, 2) == 0);
    l2_rdata         = $urandom;
    drive_ports();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy[0] || busy[1]) && n < 400) begin
      step();
      n++;
    end
    if (busy[0] || busy[1]) begin
      fail("drain_timeout");
      busy[0] = 1'b0;
      busy[1] = 1'b0;
    end
    repeat (2) step();
  endtask

  // Monitor: per-cycle expectation from the ownership model plus scoreboard.
  always @(negedge clk) begin : mon
    logic              e_v, e_icf, e_dcf;
    memory_operation_e e_t;
    logic [31:0]       e_a, e_d;
    word_t             w;
    e_v = 1'b0; e_t = LOAD; e_a = 32'h0; e_d = 32'h0; e_icf = 1'b0; e_dcf = 1'b0;
    if (m_owner == 1) begin
      e_v = ic_req_valid; e_t = ic_req_type; e_a = ic_req_address; e_icf = l2_req_fulfilled;
    end else if (m_owner == 2) begin
      e_v = dc_req_valid; e_t = dc_req_type; e_a = dc_req_address; e_d = dc_req_wdata;
      e_dcf = l2_req_fulfilled;
    end
    chk("l2_req_valid", l2_req_valid, e_v);
    chk("l2_req_type", l2_req_type, e_t);
    chk("l2_req_address", l2_req_address, e_a);
    chk("l2_req_wdata", l2_req_wdata, e_d);
    chk("ic_req_fulfilled", ic_req_fulfilled, e_icf);
    chk("dc_req_fulfilled", dc_req_fulfilled, e_dcf);
    if (ic_req_fulfilled === 1'b1 || dc_req_fulfilled === 1'b1)
      chk("rdata", rdata, l2_rdata);

    if (!reset && e_v && l2_req_fulfilled) begin
      if ((m_owner == 1 && exp_ic.size() == 0) || (m_owner == 2 && exp_dc.size() == 0)) begin
        fail("sb_underflow");
      end else begin
        w = (m_owner == 1) ? exp_ic.pop_front() : exp_dc.pop_front();
        chk("sb_address", l2_req_address, w.a);
        chk("sb_type", l2_req_type, w.t);
        chk("sb_wdata", l2_req_wdata, w.d);
      end
    end

`ifdef L2_ARB_PERF_CNT_EN
    chk("ic_grant_cycles", ic_grant_cycles, m_icc);
    chk("dc_grant_cycles", dc_grant_cycles, m_dcc);
    chk("contention_cycles", contention_cycles, m_cont);
`endif
    if (reset) begin
      m_icc = 0; m_dcc = 0; m_cont = 0;
    end else begin
      if (m_owner == 1) m_icc++;
      if (m_owner == 2) m_dcc++;
      if ((ic_req_valid && m_owner != 1) || (dc_req_valid && m_owner != 2)) m_cont++;
    end

    s_fulf[0] = ic_req_fulfilled;
    s_fulf[1] = dc_req_fulfilled;

    // Ownership rules: locked while the owner is valid, tie-break to the
    // client not served last, hand-over without a dead cycle.
    if (reset) begin
      m_owner   = 0;
      m_last_dc = 1'b1;
    end else if (m_owner == 0) begin
      if (ic_req_valid && dc_req_valid) m_owner = m_last_dc ? 1 : 2;
      else if (ic_req_valid)            m_owner = 1;
      else if (dc_req_valid)            m_owner = 2;
    end else if (m_owner == 1 && !ic_req_valid) begin
      m_last_dc = 1'b0;
      m_owner   = dc_req_valid ? 2 : 0;
    end else if (m_owner == 2 && !dc_req_valid) begin
      m_last_dc = 1'b1;
      m_owner   = ic_req_valid ? 1 : 0;
    end
  end

  initial begin
    #2_000_000;
    fail("global_timeout");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    reset = 1'b1; rnd_en = 1'b0; l2_req_fulfilled = 1'b0; l2_rdata = 32'h0;
    for (int c = 0; c < 2; c++) begin
      busy[c] = 1'b0; words_left[c] = 0; gap[c] = 0; cur_addr[c] = 32'h0;
      cur_wdata[c] = 32'h0; cur_type[c] = LOAD; s_fulf[c] = 1'b0;
    end
    drive_ports();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // Tie after reset: icache 4-word fill wins, dcache store waits.
    start_burst(0, 4, 32'h100, LOAD, 32'h0);
    start_burst(1, 1, 32'h2040, STORE, 32'hDEADBEEF);
    drive_ports();
    step();
    #2;
    chk("first_req_valid", l2_req_valid, 1'b1);
    chk("first_req_addr", l2_req_address, 32'h100);
    chk("first_req_type", l2_req_type, LOAD);
    chk("first_dc_fulfilled", dc_req_fulfilled, 1'b0);
    wait_idle();

    // Icache alone, then a fresh tie must go to the dcache.
    start_burst(0, 1, 32'h400, LOAD, 32'h0);
    drive_ports();
    wait_idle();
    start_burst(0, 2, 32'h800, LOAD, 32'h0);
    start_burst(1, 1, 32'h5000, STORE, 32'hA5A5_0001);
    drive_ports();
    l2_req_fulfilled = 1'b0;
    step();
    #2;
    chk("tie2_addr", l2_req_address, 32'h5000);
    chk("tie2_type", l2_req_type, STORE);
    chk("tie2_ic_fulfilled", ic_req_fulfilled, 1'b0);
    wait_idle();

    // Random traffic.
    rnd_en = 1'b1;
    repeat (3000) step();
    rnd_en = 1'b0;
    wait_idle();

    // Reset in the middle of a dcache burst with fulfilled pending.
    start_burst(1, 4, 32'h3000, STORE, 32'h1234_5678);
    drive_ports();
    l2_req_fulfilled = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    chk("rst_pre_valid", l2_req_valid, 1'b1);
    reset = 1'b1;
    l2_req_fulfilled = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    chk("rst_idle_valid", l2_req_valid, 1'b0);
    chk("rst_no_dc_fulfill", dc_req_fulfilled, 1'b0);
    chk("rst_no_ic_fulfill", ic_req_fulfilled, 1'b0);
    @(posedge clk); #1;
    busy[1] = 1'b0;
    exp_dc.delete();
    l2_req_fulfilled = 1'b0;
    drive_ports();
    repeat (4) step();

    chk("ic_queue_empty", exp_ic.size(), 0);
    chk("dc_queue_empty", exp_dc.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2_request_arbiter.md
Name: l2_request_arbiter

Overview:
- Sits directly downstream of the icache controller and the dcache controller.
- Merges their higher-memory request ports (l2_req_valid / l2_req_type / address / wdata, with l2_req_fulfilled back) onto the single L2 port.
- Round-robin arbitration between the two clients. A grant is locked for as long as the granted client holds its request valid, so a multi-word line fill or writeback is never interleaved with the other client's traffic.

Parameters:
- ADDR_W, 32, byte address width of every request.
- XLEN, 32, data word width.

Ports:
- clk  input  1  clock; all state on posedge.
- reset  input  1  synchronous, active-high reset.
- ic_req_valid  input  1  icache request to L2.
- ic_req_type  input  memory_operation_e  icache operation; LOAD only in practice.
- ic_req_address  input  ADDR_W  icache word address.
- ic_req_fulfilled  output  1  L2 fulfilled this icache word.
- dc_req_valid  input  1  dcache request to L2.
- dc_req_type  input  memory_operation_e  LOAD or STORE.
- dc_req_address  input  ADDR_W  dcache word address.
- dc_req_wdata  input  XLEN  dcache store data.
- dc_req_fulfilled  output  1  L2 fulfilled this dcache word.
- l2_req_valid  output  1  request to L2.
- l2_req_type  output  memory_operation_e  forwarded operation.
- l2_req_address  output  ADDR_W  forwarded address.
- l2_req_wdata  output  XLEN  forwarded store data; 0 when the icache is granted.
- l2_req_fulfilled  input  1  L2 completion pulse, one per word.
- l2_rdata  input  XLEN  L2 load data.
- rdata  output  XLEN  l2_rdata broadcast to both clients; qualified by the *_fulfilled outputs.

Behaviour:
- States:
  - ST_IDLE: no grant.
  - ST_GRANT_IC: icache owns the L2 port.
  - ST_GRANT_DC: dcache owns the L2 port.
  - Any other encoding drives next state and all outputs to X.
- last_grant register: 1 bit, 0 = IC, 1 = DC.
- Reset:
  - state <= ST_IDLE and last_grant <= DC, so the icache wins the first tie.
  - All outputs are 0 and l2_req_type = LOAD while in ST_IDLE.
- ST_IDLE transitions:
  - Only ic_req_valid: go to GRANT_IC.
  - Only dc_req_valid: go to GRANT_DC.
  - Both valid: grant the client that is not last_grant.
  - Neither valid: stay in IDLE.
  - No L2 request is issued in the IDLE cycle. Arbitration latency is 1 cycle from client valid to l2_req_valid.
- ST_GRANT_x outputs:
  - l2_req_valid = x_req_valid.
  - type, address and wdata are passed combinationally from client x.
  - x_req_fulfilled = l2_req_fulfilled.
  - The other client's fulfilled output is held at 0.
- ST_GRANT_x transitions:
  - x_req_valid high: stay in GRANT_x. The lock holds across any number of fulfilled pulses.
  - x_req_valid low: set last_grant <= x. Then go to GRANT_other if the other client is valid, else go to IDLE.
  - A direct switch costs no dead cycle. The switch cycle issues no L2 request, because l2_req_valid follows the granted client's valid, which is now 0.
- Fulfilled arriving in the same cycle the granted client drops valid: forward it to that client anyway, and change state as above.
- l2_req_fulfilled while in IDLE: ignored; both *_fulfilled outputs stay 0.
- Reset asserted mid-burst: state returns to IDLE on the next edge. Clients are reset by the same signal, so no transaction is resumed.
- Starvation bound: a client waiting while the other holds the lock is granted the first cycle after the lock releases.

Optional Feature:
- Macro: L2_ARB_PERF_CNT_EN.
- When defined:
  - Adds outputs ic_grant_cycles, dc_grant_cycles, contention_cycles, each 32 bits.
  - The grant counters count cycles spent in the corresponding GRANT state.
  - contention_cycles counts cycles in which a client is valid but not granted.
  - All counters are cleared by reset and saturate at 0xFFFFFFFF.
- When undefined: the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then ic_req_valid=1 with address 0x100 → l2_req_valid=1 one cycle later, address 0x100, type LOAD, dc_req_fulfilled stays 0.
- Icache 4-word fill: L2 pulses fulfilled 4 times while dc_req_valid=1 throughout → ic_req_fulfilled pulses exactly 4 times, dc_req_fulfilled is never asserted, GRANT_DC is entered the cycle after ic_req_valid drops.
- Both valid from IDLE after reset → icache granted first; next simultaneous contention from IDLE → dcache granted.
- Dcache STORE, address 0x2040, wdata 0xDEADBEEF → l2_req_type=STORE with that address and data; ic_req_fulfilled stays 0.
- Reset asserted during GRANT_DC with a pending fulfilled → state IDLE on the next edge, l2_req_valid=0, no fulfilled pulses forwarded.
- With L2_ARB_PERF_CNT_EN: 10-cycle icache grant while the dcache waits → ic_grant_cycles=10, contention_cycles=10 (±1 for the IDLE cycle as specified above).
